// File: rtl/rx_frame_ctrl.sv
// HDLC receive frame controller: sequences frame start, byte writes, frame end and
// error reporting between the flag/abort/zero-removal front end and the RX byte buffer.
module rx_frame_ctrl #(
    parameter int unsigned FLAG_DELAY  = 8,
    parameter int unsigned MIN_BYTES   = 4,
    parameter int unsigned MAX_BYTES   = 128,
    parameter int unsigned LEN_W       = 8,
    parameter bit          SHARED_FLAG = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             NewByte,
    input  logic             FlagDetect,
    input  logic             Abort,
    input  logic             Overflow,
    input  logic             FCSerror,
    output logic             ValidFrame,
    output logic             StartZeroDetect,
    output logic             StartFCS,
    output logic             StopFCS,
    output logic             WriteByte,
    output logic             EoF,
    output logic             AbortedFrame,
    output logic             FrameError,
    output logic [3:0]       ErrorCause,
    output logic [LEN_W-1:0] FrameLength
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StReceive,
        StOverflow,
        StCheck
    } stateT;

    localparam logic [3:0]       DelayEnd = 4'(FLAG_DELAY);
    localparam logic [LEN_W-1:0] MaxCnt   = LEN_W'(MAX_BYTES);

    stateT            state;
    logic [3:0]       delayCnt;
    logic [LEN_W-1:0] byteCnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= StIdle;
            delayCnt        <= 4'd0;
            byteCnt         <= '0;
            StartZeroDetect <= 1'b0;
            WriteByte       <= 1'b0;
            EoF             <= 1'b0;
            AbortedFrame    <= 1'b0;
            ErrorCause      <= 4'b0000;
            FrameLength     <= '0;
        end else begin
            StartZeroDetect <= 1'b0;
            WriteByte       <= 1'b0;
            EoF             <= 1'b0;
            case (state)
                StIdle: begin
                    if (FlagDetect) begin
                        state    <= StStart;
                        delayCnt <= 4'd1;
                    end
                end
                StStart: begin
                    if (Abort) begin
                        state <= StIdle;
                    end else if (FlagDetect) begin
                        // Back-to-back idle flags: the last one opens the frame.
                        delayCnt <= 4'd1;
                    end else if (delayCnt == DelayEnd) begin
                        state           <= StReceive;
                        StartZeroDetect <= 1'b1;
                        ErrorCause      <= 4'b0000;
                        AbortedFrame    <= 1'b0;
                        byteCnt         <= '0;
                    end else begin
                        delayCnt <= delayCnt + 4'd1;
                    end
                end
                StReceive, StOverflow: begin
                    if (Abort) begin
                        AbortedFrame <= 1'b1;
                        state        <= StIdle;
                    end else if (FlagDetect) begin
                        // A byte completing with the flag is the flag itself.
                        ErrorCause[0] <= ~NewByte;
                        state         <= StCheck;
                    end else if (NewByte && state == StReceive) begin
                        if (Overflow || byteCnt == MaxCnt) begin
                            state         <= StOverflow;
                            ErrorCause[3] <= 1'b1;
                        end else begin
                            WriteByte <= 1'b1;
                            byteCnt   <= byteCnt + LEN_W'(1);
                        end
                    end
                end
                StCheck: begin
                    ErrorCause[1] <= FCSerror;
                    ErrorCause[2] <= 32'(byteCnt) < MIN_BYTES;
                    FrameLength   <= byteCnt;
                    EoF           <= 1'b1;
                    delayCnt      <= 4'd1;
                    state         <= SHARED_FLAG ? StStart : StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign ValidFrame = (state == StReceive) || (state == StOverflow);
    assign StartFCS   = StartZeroDetect;
    assign StopFCS    = ValidFrame & FlagDetect & ~Abort;
    assign FrameError = |ErrorCause;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: directed and randomized frames against a
// frame-level model of expected writes, length and error cause.
module tb_rx_frame_ctrl;

    localparam int unsigned FlagDelay = 8;
    localparam int unsigned MinBytes  = 4;
    localparam int unsigned MaxBytes  = 128;
    localparam int unsigned LenW      = 8;

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic            NewByte = 1'b0;
    logic            FlagDetect = 1'b0;
    logic            Abort = 1'b0;
    logic            Overflow = 1'b0;
    logic            FCSerror = 1'b0;
    logic            ValidFrame;
    logic            StartZeroDetect;
    logic            StartFCS;
    logic            StopFCS;
    logic            WriteByte;
    logic            EoF;
    logic            AbortedFrame;
    logic            FrameError;
    logic [3:0]      ErrorCause;
    logic [LenW-1:0] FrameLength;

    int checks   = 0;
    int failures = 0;
    int wrCount  = 0;
    int eofCount = 0;
    int szdCount = 0;
    int expWr    = 0;
    int expEof   = 0;
    int lastLen  = 0;

    rx_frame_ctrl #(
        .FLAG_DELAY (FlagDelay),
        .MIN_BYTES  (MinBytes),
        .MAX_BYTES  (MaxBytes),
        .LEN_W      (LenW),
        .SHARED_FLAG(1'b1)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .NewByte        (NewByte),
        .FlagDetect     (FlagDetect),
        .Abort          (Abort),
        .Overflow       (Overflow),
        .FCSerror       (FCSerror),
        .ValidFrame     (ValidFrame),
        .StartZeroDetect(StartZeroDetect),
        .StartFCS       (StartFCS),
        .StopFCS        (StopFCS),
        .WriteByte      (WriteByte),
        .EoF            (EoF),
        .AbortedFrame   (AbortedFrame),
        .FrameError     (FrameError),
        .ErrorCause     (ErrorCause),
        .FrameLength    (FrameLength)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (WriteByte) wrCount <= wrCount + 1;
        if (EoF) eofCount <= eofCount + 1;
        if (StartZeroDetect) szdCount <= szdCount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cyc(input bit nb, input bit fd, input bit ab);
        NewByte    = nb;
        FlagDetect = fd;
        Abort      = ab;
        step();
        NewByte    = 1'b0;
        FlagDetect = 1'b0;
        Abort      = 1'b0;
    endtask

    function automatic logic [31:0] allOuts();
        return 32'({ValidFrame, StartZeroDetect, StartFCS, StopFCS, WriteByte, EoF,
                    AbortedFrame, FrameError, ErrorCause, FrameLength});
    endfunction

    // Opens a frame either from IDLE (fresh flag) or from the shared closing flag;
    // k counts edges since the edge that sampled the opening flag.
    task automatic open_frame(input bit fresh, input bit doubleFlag);
        int k;
        int expLat;
        int g;
        bit seen;
        k = 1;
        expLat = FlagDelay + 1;
        if (fresh) begin
            FlagDetect = 1'b1;
            #1;
            chk("stopfcs_idle_flag", 32'(StopFCS), 32'(0));
            step();
            FlagDetect = 1'b0;
            if (doubleFlag) begin
                g = $urandom_range(1, FlagDelay - 1);
                repeat (g) cyc(0, 0, 0);
                cyc(0, 1, 0);
            end
            k = 0;
            expLat = FlagDelay;
        end
        seen = 1'b0;
        while (!seen && k < 40) begin
            cyc(0, 0, 0);
            k++;
            seen = StartZeroDetect;
        end
        chk("szd_latency", k, expLat);
        chk("szd_state", 32'({StartFCS, ValidFrame, AbortedFrame, ErrorCause}), 32'(7'b1100000));
        chk("wr_total", wrCount, expWr);
        chk("eof_total", eofCount, expEof);
        cyc(0, 0, 0);
        chk("szd_pulse", 32'({StartZeroDetect, ValidFrame}), 32'(2'b01));
    endtask

    // Model: bytes are written until the first one seen with Overflow or at MAX_BYTES.
    task automatic send_bytes(input int n, input int ovAt, output int writes);
        int lim;
        lim = (ovAt >= 0 && ovAt < n) ? ovAt : n;
        if (lim > int'(MaxBytes)) lim = MaxBytes;
        for (int i = 0; i < n; i++) begin
            if (ovAt >= 0 && i >= ovAt) Overflow = 1'b1;
            repeat ($urandom_range(0, 2)) cyc(0, 0, 0);
            cyc(1, 0, 0);
            chk("write_pulse", 32'(WriteByte), 32'(i < lim));
        end
        writes = lim;
    endtask

    task automatic close_frame(input bit aligned, input bit fcs, input int n, input int writes);
        logic [3:0] ec;
        ec = {n > writes, writes < int'(MinBytes), fcs, !aligned};
        NewByte    = aligned;
        FlagDetect = 1'b1;
        #1;
        chk("stopfcs_close", 32'(StopFCS), 32'(1));
        @(posedge Clk);
        #1;
        NewByte    = 1'b0;
        FlagDetect = 1'b0;
        chk("check_cycle", 32'({ValidFrame, EoF, WriteByte}), 32'(0));
        FCSerror = fcs;
        step();
        FCSerror = 1'b0;
        Overflow = 1'b0;
        chk("eof", 32'(EoF), 32'(1));
        chk("frame_len", 32'(FrameLength), writes);
        chk("err_cause", 32'(ErrorCause), 32'(ec));
        chk("frame_err", 32'(FrameError), 32'(|ec));
        expWr  += writes;
        expEof += 1;
        lastLen = writes;
    endtask

    initial begin
        int w;
        int n;
        int ovAt;
        bit al;
        bit fe;

        // Reset wins over a coincident flag.
        Rst = 1'b1;
        repeat (2) step();
        cyc(0, 1, 0);
        chk("reset_outputs", allOuts(), 32'(0));
        Rst = 1'b0;

        cyc(0, 0, 1);
        chk("abort_idle", 32'({AbortedFrame, ValidFrame}), 32'(0));

        // Abort during START returns to IDLE with no frame and no abort flag.
        cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(0, 0, 1);
        repeat (FlagDelay + 3) cyc(0, 0, 0);
        chk("abort_start_szd", szdCount, 0);
        chk("abort_start_state", 32'({ValidFrame, AbortedFrame}), 32'(0));

        // 3-byte frame, unaligned close, FCS error.
        open_frame(1'b1, 1'b0);
        send_bytes(3, -1, w);
        close_frame(1'b0, 1'b1, 3, w);
        chk("ec_held", 32'(ErrorCause), 32'(4'b0111));

        // Shared flag opens a clean 6-byte frame.
        open_frame(1'b0, 1'b0);
        send_bytes(6, -1, w);
        close_frame(1'b1, 1'b0, 6, w);

        // Overflow before the 3rd byte.
        open_frame(1'b0, 1'b0);
        send_bytes(6, 2, w);
        close_frame(1'b1, 1'b0, 6, w);

        // Too long: saturates at MAX_BYTES.
        open_frame(1'b0, 1'b0);
        send_bytes(130, -1, w);
        close_frame(1'b1, 1'b0, 130, w);

        // Abort after 4 bytes, coinciding with a flag.
        open_frame(1'b0, 1'b0);
        send_bytes(4, -1, w);
        expWr += w;
        Abort      = 1'b1;
        FlagDetect = 1'b1;
        #1;
        chk("stopfcs_abort", 32'(StopFCS), 32'(0));
        @(posedge Clk);
        #1;
        Abort      = 1'b0;
        FlagDetect = 1'b0;
        chk("abort_frame", 32'({ValidFrame, AbortedFrame, EoF}), 32'(3'b010));
        repeat (FlagDelay + 3) cyc(0, 0, 0);
        chk("abort_idle_after", 32'({ValidFrame, AbortedFrame}), 32'(2'b01));
        chk("abort_len_kept", 32'(FrameLength), lastLen);
        chk("abort_no_eof", eofCount, expEof);

        // Randomized chain of shared-flag frames.
        open_frame(1'b1, 1'($urandom_range(0, 1)));
        for (int r = 0; r < 8; r++) begin
            if (r > 0) open_frame(1'b0, 1'b0);
            n    = $urandom_range(0, 12);
            ovAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            al   = 1'($urandom_range(0, 1));
            fe   = 1'($urandom_range(0, 1));
            send_bytes(n, ovAt, w);
            close_frame(al, fe, n, w);
        end

        // Reset mid-frame: outputs clear and no EoF follows.
        open_frame(1'b0, 1'b0);
        send_bytes(2, -1, w);
        expWr += w;
        Rst = 1'b1;
        step();
        chk("reset_midframe", allOuts(), 32'(0));
        Rst = 1'b0;
        repeat (FlagDelay + 3) cyc(0, 0, 0);
        chk("reset_no_eof", eofCount, expEof);
        chk("reset_wr_total", wrCount, expWr);
        chk("reset_idle", 32'(ValidFrame), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
